// File: rtl/gearbox_pkg.sv
// Shared constants and types for the 66b->32b TX gearbox sequencer.
package gearbox_pkg;

    localparam int unsigned GB_PERIOD = 33;  // cycles per gearbox period
    localparam int unsigned GB_WORDS  = 32;  // word-enable cycles per period
    localparam int unsigned GB_BLOCKS = 16;  // blocks carried per period
    localparam int unsigned PHASE_W   = 6;   // wide enough for 0..GB_PERIOD-1

    localparam logic [1:0]  HDR_DATA = 2'b01;
    localparam logic [1:0]  HDR_CTRL = 2'b10;
    localparam logic [63:0] BLK_IDLE = 64'h0000_0000_0000_001E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Last phase of the period: the gap cycle in which the gearbox flushes.
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(GB_PERIOD - 1);

    // A new block is pulled on every even word slot.
    function automatic logic is_fetch_phase(input logic [PHASE_W-1:0] phase);
        return (phase < PHASE_W'(GB_WORDS)) && !phase[0];
    endfunction

endpackage

// File: rtl/gearbox_tx_sched_32b.sv
// Feeds the 66b->32b TX gearbox: two 32-bit words per 64b/66b block, 16 blocks
// in 32 enable cycles followed by one gap cycle. Substitutes an idle fill block
// when the source has nothing to offer and counts those substitutions.
module gearbox_tx_sched_32b
    import gearbox_pkg::*;
#(
    parameter logic [1:0]  FILL_HDR  = HDR_CTRL,
    parameter logic [63:0] FILL_DATA = BLK_IDLE,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [63:0]      blk_data,
    input  logic [1:0]       blk_hdr,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic [31:0]      gb_din,
    output logic [1:0]       gb_ctrl,
    output logic             gb_din_en,
    output logic             gb_even,
    output logic             running,
    output logic             underflow,
    input  logic             underflow_clr,
    output logic [CNT_W-1:0] underflow_cnt
);

    sched_state_t         state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [31:0]          hi_q, hi_d;        // high half of the block in flight
    logic [31:0]          din_q, din_d;
    logic [1:0]           ctrl_q, ctrl_d;
    logic                 din_en_q, din_en_d;
    logic                 even_q, even_d;
    logic                 uf_q, uf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_base;

    logic                 active;
    logic                 last;
    logic [63:0]          fetch_data;
    logic [1:0]           fetch_hdr;

    assign active = (state_q != IDLE);
    assign last   = (phase_q == PHASE_LAST);

    // Fetch depends only on state/phase so the source sees a fixed schedule.
    assign blk_ready  = active && is_fetch_phase(phase_q);
    assign fetch_data = blk_valid ? blk_data : FILL_DATA;
    assign fetch_hdr  = blk_valid ? blk_hdr  : FILL_HDR;

    // Next state and phase: a started period always runs to its gap cycle.
    always_comb begin
        state_d = state_q;
        phase_d = '0;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (last)     state_d = en ? RUN : IDLE;
                else if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (active && !last) phase_d = phase_q + PHASE_W'(1);
    end

    // Word slicing: low half straight from the fetch, high half from the hold register.
    always_comb begin
        hi_d     = hi_q;
        din_d    = '0;
        ctrl_d   = '0;
        din_en_d = 1'b0;
        even_d   = 1'b0;
        if (blk_ready) hi_d = fetch_data[63:32];
        if (active && !last) begin
            din_en_d = 1'b1;
            if (!phase_q[0]) begin
                din_d  = fetch_data[31:0];
                ctrl_d = fetch_hdr;
                even_d = 1'b1;
            end else begin
                din_d  = hi_q;
            end
        end
    end

    // Underflow flag and saturating counter; a same-cycle event beats the clear.
    always_comb begin
        cnt_base = underflow_clr ? '0 : cnt_q;
        uf_d     = underflow_clr ? 1'b0 : uf_q;
        cnt_d    = cnt_base;
        if (blk_ready && !blk_valid) begin
            uf_d  = 1'b1;
            cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        end
    end

    // State, phase, hold and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            hi_q     <= '0;
            din_q    <= '0;
            ctrl_q   <= '0;
            din_en_q <= 1'b0;
            even_q   <= 1'b0;
            uf_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
            din_q    <= din_d;
            ctrl_q   <= ctrl_d;
            din_en_q <= din_en_d;
            even_q   <= even_d;
            uf_q     <= uf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gb_din        = din_q;
    assign gb_ctrl       = ctrl_q;
    assign gb_din_en     = din_en_q;
    assign gb_even       = even_q;
    assign running       = active;
    assign underflow     = uf_q;
    assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_gearbox_tx_sched_32b.sv
// Directed bench for gearbox_tx_sched_32b: startup, fill substitution, drain,
// mid-period reset, counter saturation and clear/event collision.
module tb_gearbox_tx_sched_32b;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] blk_data;
    logic [1:0]  blk_hdr;
    logic        blk_valid;
    logic        underflow_clr;

    logic        blk_ready, gb_din_en, gb_even, running, underflow;
    logic [31:0] gb_din;
    logic [1:0]  gb_ctrl;
    logic [15:0] underflow_cnt;

    logic        blk_ready4, gb_din_en4, gb_even4, running4, underflow4;
    logic [31:0] gb_din4;
    logic [1:0]  gb_ctrl4;
    logic [3:0]  underflow_cnt4;

    int total = 0;
    int bad   = 0;
    int blk_n = 0;
    int n_xfer;
    int n_low;
    int k;

    always #5 clk = ~clk;

    gearbox_tx_sched_32b dut (
        .clk(clk), .rst(rst), .en(en), .blk_data(blk_data), .blk_hdr(blk_hdr),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .gb_din(gb_din), .gb_ctrl(gb_ctrl),
        .gb_din_en(gb_din_en), .gb_even(gb_even), .running(running),
        .underflow(underflow), .underflow_clr(underflow_clr), .underflow_cnt(underflow_cnt)
    );

    gearbox_tx_sched_32b #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .blk_data(blk_data), .blk_hdr(blk_hdr),
        .blk_valid(blk_valid), .blk_ready(blk_ready4), .gb_din(gb_din4), .gb_ctrl(gb_ctrl4),
        .gb_din_en(gb_din_en4), .gb_even(gb_even4), .running(running4),
        .underflow(underflow4), .underflow_clr(underflow_clr), .underflow_cnt(underflow_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; source advances to the next block after each handshake.
    task automatic step(input int n = 1);
        logic x;
        for (int i = 0; i < n; i++) begin
            x = blk_ready && blk_valid;
            if (x) n_xfer++;
            if (!gb_din_en) n_low++;
            @(posedge clk);
            #1;
            if (x && rst) blk_n++;
            blk_data = {32'(2 * blk_n + 1), 32'(2 * blk_n)};
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; blk_valid = 1'b1; underflow_clr = 1'b0;
        blk_hdr = 2'b01; blk_data = {32'd1, 32'd0};
        n_xfer = 0; n_low = 0;

        // Reset state
        step(4);
        check("rst_din_en", 64'(gb_din_en), 64'd0);
        check("rst_din", 64'(gb_din), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        check("rst_ready", 64'(blk_ready), 64'd0);
        check("rst_uf_cnt", 64'(underflow_cnt), 64'd0);

        // Startup: IDLE -> RUN, phase 0
        rst = 1'b1;
        step();
        check("p0_running", 64'(running), 64'd1);
        check("p0_ready", 64'(blk_ready), 64'd1);
        check("p0_din_en", 64'(gb_din_en), 64'd0);
        step();                                   // phase 1
        check("p1_din", 64'(gb_din), 64'h0);
        check("p1_ctrl", 64'(gb_ctrl), 64'h1);
        check("p1_even", 64'(gb_even), 64'd1);
        check("p1_din_en", 64'(gb_din_en), 64'd1);
        check("p1_ready", 64'(blk_ready), 64'd0);
        step();                                   // phase 2
        check("p2_din", 64'(gb_din), 64'h1);
        check("p2_ctrl", 64'(gb_ctrl), 64'h0);
        check("p2_even", 64'(gb_even), 64'd0);
        step();                                   // phase 3
        check("p3_din", 64'(gb_din), 64'h2);
        step();                                   // phase 4
        check("p4_din", 64'(gb_din), 64'h3);

        // Underflow at phase 4
        blk_valid = 1'b0;
        step();                                   // phase 5
        blk_valid = 1'b1;
        check("fill_lo", 64'(gb_din), 64'h1E);
        check("fill_hdr", 64'(gb_ctrl), 64'h2);
        check("fill_uf", 64'(underflow), 64'd1);
        check("fill_cnt", 64'(underflow_cnt), 64'd1);
        step();                                   // phase 6
        check("fill_hi", 64'(gb_din), 64'h0);
        check("fill_hi_ctrl", 64'(gb_ctrl), 64'h0);
        step();                                   // phase 7
        check("after_fill", 64'(gb_din), 64'h4);
        check("after_fill_ctrl", 64'(gb_ctrl), 64'h1);

        // Any 33-cycle window: 16 transfers, one gap cycle
        n_xfer = 0; n_low = 0;
        step(33);                                 // phase 7 of next period
        check("win_xfer", 64'(n_xfer), 64'd16);
        check("win_gap", 64'(n_low), 64'd1);

        // Drain: en drops at phase 10; DRAIN ignores en
        step(3);                                  // phase 10
        en = 1'b0;
        n_xfer = 0;
        step(4);                                  // phase 14
        en = 1'b1;
        step(6);                                  // phase 20
        check("drain_running", 64'(running), 64'd1);
        en = 1'b0;
        step(13);                                 // wrapped to IDLE
        check("drain_xfer", 64'(n_xfer), 64'd11);
        check("drain_idle", 64'(running), 64'd0);
        check("drain_ready", 64'(blk_ready), 64'd0);
        check("drain_din_en", 64'(gb_din_en), 64'd0);
        step(3);
        check("idle_din_en", 64'(gb_din_en), 64'd0);
        check("idle_xfer", 64'(n_xfer), 64'd11);
        check("idle_running", 64'(running), 64'd0);

        // Reset mid-period at phase 17
        en = 1'b1;
        step();                                   // phase 0
        step(17);                                 // phase 17
        check("p17_running", 64'(running), 64'd1);
        rst = 1'b0;
        step();
        check("mrst_din_en", 64'(gb_din_en), 64'd0);
        check("mrst_din", 64'(gb_din), 64'd0);
        check("mrst_ctrl", 64'(gb_ctrl), 64'd0);
        check("mrst_even", 64'(gb_even), 64'd0);
        check("mrst_running", 64'(running), 64'd0);
        check("mrst_uf", 64'(underflow), 64'd0);
        rst = 1'b1;
        step();                                   // phase 0
        check("rest_ready", 64'(blk_ready), 64'd1);
        check("rest_din_en", 64'(gb_din_en), 64'd0);
        k = blk_n;
        step();                                   // phase 1
        check("rest_din", 64'(gb_din), 64'(32'(2 * k)));
        check("rest_ctrl", 64'(gb_ctrl), 64'h1);
        check("rest_even", 64'(gb_even), 64'd1);

        // Permanent underflow: 19 fetches in 40 cycles, 4-bit counter saturates
        blk_valid = 1'b0;
        step(40);                                 // phase 8
        check("sat_cnt16", 64'(underflow_cnt), 64'd19);
        check("sat_cnt4", 64'(underflow_cnt4), 64'd15);
        check("sat_uf4", 64'(underflow4), 64'd1);
        step();                                   // phase 9
        underflow_clr = 1'b1;
        step();                                   // phase 10
        underflow_clr = 1'b0;
        check("clr_cnt4", 64'(underflow_cnt4), 64'd0);
        check("clr_uf4", 64'(underflow4), 64'd0);
        check("clr_cnt16", 64'(underflow_cnt), 64'd0);
        step();                                   // phase 11
        check("reinc_cnt4", 64'(underflow_cnt4), 64'd1);
        check("reinc_uf", 64'(underflow), 64'd1);
        step();                                   // phase 12
        check("hold_cnt", 64'(underflow_cnt), 64'd1);

        // Clear and underflow event in the same cycle
        underflow_clr = 1'b1;
        step();                                   // phase 13
        underflow_clr = 1'b0;
        check("coll_uf", 64'(underflow), 64'd1);
        check("coll_cnt", 64'(underflow_cnt), 64'd1);
        check("coll_cnt4", 64'(underflow_cnt4), 64'd1);
        check("coll_din", 64'(gb_din), 64'h1E);
        check("coll_ctrl", 64'(gb_ctrl), 64'h2);
        step(2);                                  // phase 15
        check("post_cnt", 64'(underflow_cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
